// File: rtl/m21_dataflow.sv
// 2:1 dataflow multiplexer with a registered copy of the output and a saturating
// counter of select changes for debug observability.
module m21_dataflow #(
   parameter int unsigned WIDTH = 1,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i0,
   input  logic [WIDTH-1:0] i1,
   input  logic             s0,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic [CNT_W-1:0] sel_toggles
);

   logic [WIDTH-1:0] out_d;
   logic             s0_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Primary output is purely combinational and never sees clk or rst.
   assign out   = s0 ? i1 : i0;
   assign out_d = out;

   always_comb begin
      cnt_d = cnt_q;
      if ((s0 != s0_q) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
         s0_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         out_q <= out_d;
         s0_q  <= s0;
         cnt_q <= cnt_d;
      end
   end

   assign sel_toggles = cnt_q;

endmodule

// File: tb/tb_m21_dataflow.sv
// Scoreboard bench for m21_dataflow: combinational, registered and counter paths across
// WIDTH=1/CNT_W=8, WIDTH=1/CNT_W=2 and WIDTH=8 instances.
module tb_m21_dataflow;

   logic       clk = 1'b0;
   logic       rst;
   logic       i0, i1, s0;
   logic [7:0] i0_8, i1_8;
   logic       s0_8;

   logic       out_a, out_q_a, out_b, out_q_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [7:0] out_8, out_q_8;
   logic [7:0] cnt_8;

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] exp_comb_q[$];
   logic [31:0] exp_outq_q[$];
   logic [31:0] exp_cnta_q[$];
   logic [31:0] exp_cntb_q[$];

   // Reference state for the registered path.
   logic m_prev;
   int   m_cnt_a, m_cnt_b;

   always #5 clk = ~clk;

   m21_dataflow #(.WIDTH(1), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .i0(i0), .i1(i1), .s0(s0),
      .out(out_a), .out_q(out_q_a), .sel_toggles(cnt_a)
   );

   m21_dataflow #(.WIDTH(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .i0(i0), .i1(i1), .s0(s0),
      .out(out_b), .out_q(out_q_b), .sel_toggles(cnt_b)
   );

   m21_dataflow #(.WIDTH(8), .CNT_W(8)) dut_8 (
      .clk(clk), .rst(rst), .i0(i0_8), .i1(i1_8), .s0(s0_8),
      .out(out_8), .out_q(out_q_8), .sel_toggles(cnt_8)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drive combinational inputs, push expected out, let them settle, pop and compare.
   task automatic comb_step(input logic a, input logic b, input logic s, input int dly);
      i0 = a;
      i1 = b;
      s0 = s;
      exp_comb_q.push_back({31'b0, s ? b : a});
      #dly;
      check_eq("out", {31'b0, out_a}, exp_comb_q.pop_front());
   endtask

   // One clock edge on the current inputs; expectations pushed before the edge.
   task automatic clk_step();
      if (rst) begin
         m_prev  = 1'b0;
         m_cnt_a = 0;
         m_cnt_b = 0;
         exp_outq_q.push_back(32'd0);
      end else begin
         if (s0 != m_prev) begin
            if (m_cnt_a < 255) m_cnt_a++;
            if (m_cnt_b < 3)   m_cnt_b++;
         end
         m_prev = s0;
         exp_outq_q.push_back({31'b0, s0 ? i1 : i0});
      end
      exp_cnta_q.push_back(32'(m_cnt_a));
      exp_cntb_q.push_back(32'(m_cnt_b));
      @(posedge clk);
      #1;
      begin
         logic [31:0] e;
         e = exp_outq_q.pop_front();
         check_eq("out_q", {31'b0, out_q_a}, e);
         check_eq("out_q_cw2", {31'b0, out_q_b}, e);
      end
      check_eq("sel_toggles", {24'b0, cnt_a}, exp_cnta_q.pop_front());
      check_eq("sel_toggles_cw2", {30'b0, cnt_b}, exp_cntb_q.pop_front());
   endtask

   initial begin
      rst  = 1'b1;
      i0   = 1'b0;
      i1   = 1'b0;
      s0   = 1'b0;
      i0_8 = 8'h00;
      i1_8 = 8'h00;
      s0_8 = 1'b0;
      m_prev  = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;

      // Combinational sequence, 10 time units apart.
      comb_step(1'b0, 1'b0, 1'b0, 10);
      check_eq("seq_out0", {31'b0, out_a}, 32'd0);
      comb_step(1'b1, 1'b0, 1'b0, 10);
      check_eq("seq_out1", {31'b0, out_a}, 32'd1);
      comb_step(1'b1, 1'b0, 1'b1, 10);
      check_eq("seq_out2", {31'b0, out_a}, 32'd0);
      comb_step(1'b1, 1'b1, 1'b1, 10);
      check_eq("seq_out3", {31'b0, out_a}, 32'd1);

      // Exhaustive, minimal settle time.
      for (int k = 0; k < 8; k++) begin
         logic [2:0] v;
         v = 3'(k);
         comb_step(v[0], v[1], v[2], 1);
         check_eq("out_cw2", {31'b0, out_b}, {31'b0, v[2] ? v[1] : v[0]});
      end

      // Reset for 2 clocks.
      @(negedge clk);
      rst = 1'b1;
      i0  = 1'b1;
      i1  = 1'b0;
      s0  = 1'b0;
      clk_step();
      clk_step();
      check_eq("rst_out_q", {31'b0, out_q_a}, 32'd0);
      check_eq("rst_sel", {24'b0, cnt_a}, 32'd0);

      // Release with i0=1, s0=0: out_q=1 one clock later.
      rst = 1'b0;
      clk_step();
      check_eq("release_out_q", {31'b0, out_q_a}, 32'd1);
      check_eq("release_sel", {24'b0, cnt_a}, 32'd0);

      // Five consecutive toggles, then a sixth to show CNT_W=2 saturation.
      for (int k = 0; k < 5; k++) begin
         s0 = ~s0;
         clk_step();
      end
      check_eq("toggle5", {24'b0, cnt_a}, 32'd5);
      s0 = ~s0;
      clk_step();
      check_eq("toggle6", {24'b0, cnt_a}, 32'd6);
      check_eq("sat_cw2", {30'b0, cnt_b}, 32'd3);

      // Build out_q=1, sel_toggles=4 from a fresh reset.
      rst = 1'b1;
      clk_step();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         s0 = ~s0;
         clk_step();
      end
      check_eq("pre_rst_out_q", {31'b0, out_q_a}, 32'd1);
      check_eq("pre_rst_sel", {24'b0, cnt_a}, 32'd4);

      // Mid-run reset for one clock; out keeps following inputs.
      rst = 1'b1;
      comb_step(1'b0, 1'b1, 1'b1, 1);
      clk_step();
      check_eq("midrst_out_q", {31'b0, out_q_a}, 32'd0);
      check_eq("midrst_sel", {24'b0, cnt_a}, 32'd0);
      comb_step(1'b0, 1'b1, 1'b0, 1);
      comb_step(1'b1, 1'b0, 1'b0, 1);
      rst = 1'b0;
      s0  = 1'b1;
      clk_step();
      check_eq("resume_sel", {24'b0, cnt_a}, 32'd1);

      // WIDTH=8 path.
      i0_8 = 8'hA5;
      i1_8 = 8'h3C;
      s0_8 = 1'b0;
      #1;
      check_eq("w8_s0", {24'b0, out_8}, 32'h0000_00A5);
      s0_8 = 1'b1;
      #1;
      check_eq("w8_s1", {24'b0, out_8}, 32'h0000_003C);
      @(posedge clk);
      #1;
      check_eq("w8_out_q", {24'b0, out_q_8}, 32'h0000_003C);

      check_eq("sb_drained", 32'(exp_outq_q.size() + exp_comb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
